// File: rtl/imem_fetch.sv
// Instruction memory fetch unit: a DEPTH x 32 word store with a LAT-stage read
// pipeline feeding a small in-order response queue. Faulted fetches (misaligned
// or out of range) travel the same path and return NOP_WORD with an error code.
module imem_fetch #(
  parameter int          DEPTH    = 256,
  parameter int          LAT      = 1,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic [1:0]  rsp_err,
  input  logic        flush,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] fetch_cnt
);

  localparam int AW = $clog2(DEPTH);
  // Total slots shared between in-flight reads and queued responses.
  localparam int QD = LAT + 1;

  // Word store; power-up contents are zero and reset never touches them.
  logic [31:0] r_mem [DEPTH] = '{default: '0};

  // Read pipeline, one entry per cycle of latency.
  logic        r_pv [LAT];
  logic [31:0] r_pa [LAT];
  logic [1:0]  r_pe [LAT];
  logic [31:0] r_rd [LAT];

  // Response queue; arrays are sized to the 2-bit pointer range but the
  // pointers only cycle through QD entries.
  logic [31:0] r_q_instr [4];
  logic [31:0] r_q_addr  [4];
  logic [1:0]  r_q_err   [4];
  logic [1:0]  r_wp;
  logic [1:0]  r_rp;
  logic [1:0]  r_cnt;

  logic [1:0]  r_occ;
  logic [31:0] r_fetch_cnt;

  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_req_idx;
  logic [AW-1:0] w_ld_idx;
  logic          w_ld_ok;
  logic [1:0]    w_req_err;
  logic [31:0]   w_out_instr;
  logic [1:0]    w_wp_next;
  logic [1:0]    w_rp_next;
  logic          w_unused;

  assign w_unused  = ^ld_addr[1:0];
  assign w_req_idx = req_addr[AW+1:2];
  assign w_ld_idx  = ld_addr[AW+1:2];
  assign w_ld_ok   = (ld_addr[31:2] < 30'(DEPTH));

  // Misalignment is reported ahead of range errors.
  assign w_req_err = (req_addr[1:0] != 2'b00)       ? 2'b01 :
                     (req_addr[31:2] >= 30'(DEPTH)) ? 2'b10 : 2'b00;

  // A pop frees a slot in the same cycle, which keeps one fetch per cycle going.
  assign req_ready = !rst && !flush && ((r_occ < 2'(QD)) || w_pop);
  assign w_accept  = req_valid && req_ready;
  assign w_pop     = rsp_valid && rsp_ready;

  // Pipeline exit: faulted fetches substitute the NOP word for the RAM data.
  assign w_out_instr = (r_pe[LAT-1] != 2'b00) ? NOP_WORD : r_rd[LAT-1];
  assign w_push      = r_pv[LAT-1] && !flush;

  assign w_wp_next = (r_wp == 2'(QD - 1)) ? 2'd0 : r_wp + 2'd1;
  assign w_rp_next = (r_rp == 2'(QD - 1)) ? 2'd0 : r_rp + 2'd1;

  // Program load port; blocked only by reset, and out-of-range words are dropped.
  always_ff @(posedge clk) begin
    if (!rst && ld_en && w_ld_ok) begin
      r_mem[w_ld_idx] <= ld_data;
    end
  end

  // Registered RAM read plus the delay stages that carry address and error along.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_pv[0] <= 1'b0;
    end else begin
      r_pv[0] <= w_accept;
    end
    if (w_accept) begin
      r_pa[0] <= req_addr;
      r_pe[0] <= w_req_err;
      r_rd[0] <= r_mem[w_req_idx];
    end
    for (int i = 1; i < LAT; i++) begin
      r_pv[i] <= (rst || flush) ? 1'b0 : r_pv[i-1];
      r_pa[i] <= r_pa[i-1];
      r_pe[i] <= r_pe[i-1];
      r_rd[i] <= r_rd[i-1];
    end
  end

  // Response queue: push from the pipeline exit, pop on handshake.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wp  <= 2'd0;
      r_rp  <= 2'd0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_q_instr[r_wp] <= w_out_instr;
        r_q_addr[r_wp]  <= r_pa[LAT-1];
        r_q_err[r_wp]   <= r_pe[LAT-1];
        r_wp            <= w_wp_next;
      end
      if (w_pop) begin
        r_rp <= w_rp_next;
      end
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  // Slot accounting across pipeline and queue; flush and reset empty both.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ <= 2'd0;
    end else begin
      r_occ <= r_occ + 2'(w_accept) - 2'(w_pop);
    end
  end

  // Delivered-response counter; a pop in a flush cycle still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'd0;
    end else if (w_pop) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign rsp_valid = (r_cnt != 2'd0);
  // Outputs read as zero while the queue is empty so reset leaves them clean.
  assign rsp_instr = rsp_valid ? r_q_instr[r_rp] : 32'd0;
  assign rsp_addr  = rsp_valid ? r_q_addr[r_rp]  : 32'd0;
  assign rsp_err   = rsp_valid ? r_q_err[r_rp]   : 2'b00;

endmodule
